if_stage: RTL and testbench

//   Instruction-fetch stage plus IF/ID pipeline register of the RV32I pipelined core.

---
 rtl/if_stage.sv | 113 +++++++++++
 tb/tb_if_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the RV32I pipelined core.
// Owns the PC, fetches one word per cycle and inserts bubbles on redirect or memory wait.
module if_stage #(
    parameter int unsigned     PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
    parameter int unsigned     CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [PC_W-1:0]  imem_addr_o,
    input  logic [31:0]      imem_rdata_i,
    input  logic             imem_valid_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [PC_W-1:0]  redirect_pc_i,
    output logic             id_valid_o,
    output logic [PC_W-1:0]  id_pc_o,
    output logic [31:0]      id_instr_o,
    output logic [6:0]       id_opcode_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    typedef enum logic [1:0] {
        ActFetch,
        ActWait,
        ActStall,
        ActRedirect
    } action_e;

    action_e          action;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             id_valid_q, id_valid_d;
    logic [PC_W-1:0]  id_pc_q, id_pc_d;
    logic [31:0]      id_instr_q, id_instr_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             bubble;

    // Fixed priority: redirect beats stall beats fetch/wait.
    always_comb begin
        action = ActFetch;
        if (redirect_i) begin
            action = ActRedirect;
        end else if (stall_i) begin
            action = ActStall;
        end else if (!imem_valid_i) begin
            action = ActWait;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        bubble     = 1'b0;
        unique case (action)
            ActRedirect: begin
                pc_d       = {redirect_pc_i[PC_W-1:2], 2'b00};
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
                bubble     = 1'b1;
            end
            ActStall: begin
            end
            ActWait: begin
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
                bubble     = 1'b1;
            end
            ActFetch: begin
                pc_d       = pc_q + PC_W'(4);
                id_valid_d = 1'b1;
                id_pc_d    = pc_q;
                id_instr_d = imem_rdata_i;
            end
            default: begin
            end
        endcase
    end

    // Saturating: once all-ones the counter sticks.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_instr_q   <= NOP_INSTR;
            bubble_cnt_q <= '0;
        end else begin
            pc_q         <= pc_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign imem_addr_o  = pc_q;
    assign id_valid_o   = id_valid_q;
    assign id_pc_o      = id_pc_q;
    assign id_instr_o   = id_instr_q;
    assign id_opcode_o  = id_instr_q[6:0];
    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: fetch, stall, redirect, wait,
// PC wrap, bubble counter saturation and asynchronous reset.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic [15:0] bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr_o  (imem_addr),
        .imem_rdata_i (imem_rdata),
        .imem_valid_i (imem_valid),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .id_valid_o   (id_valid),
        .id_pc_o      (id_pc),
        .id_instr_o   (id_instr),
        .id_opcode_o  (id_opcode),
        .bubble_cnt_o (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, " addr"},   imem_addr,           32'h0);
        check_eq({tag, " valid"},  {31'b0, id_valid},   32'h0);
        check_eq({tag, " id_pc"},  id_pc,               32'h0);
        check_eq({tag, " instr"},  id_instr,            32'h0000_0013);
        check_eq({tag, " cnt"},    {16'b0, bubble_cnt}, 32'h0);
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_rdata  = 32'h0050_0093;
        imem_valid  = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        repeat (2) @(posedge clk);
        #2;
        check_reset("reset");
        rst_n = 1'b1;

        // Streaming fetch: PC advances by 4, id_pc lags one cycle.
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("seq addr",  imem_addr, 32'(4 * i));
            check_eq("seq id_pc", id_pc,     32'(4 * (i - 1)));
        end
        check_eq("seq valid",  {31'b0, id_valid},  32'h1);
        check_eq("seq opcode", {25'b0, id_opcode}, 32'h13);
        check_eq("seq instr",  id_instr,           32'h0050_0093);

        // Three stall cycles at pc=0x10: everything frozen, no bubbles.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall addr",  imem_addr, 32'h10);
            check_eq("stall id_pc", id_pc,     32'h0C);
        end
        check_eq("stall cnt", {16'b0, bubble_cnt}, 32'h0);
        stall = 1'b0;
        tick();
        check_eq("unstall id_pc", id_pc,     32'h10);
        check_eq("unstall addr",  imem_addr, 32'h14);

        // Redirect wins over stall; low address bits dropped.
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h103;
        tick();
        check_eq("redir addr",  imem_addr,           32'h100);
        check_eq("redir valid", {31'b0, id_valid},   32'h0);
        check_eq("redir instr", id_instr,            32'h0000_0013);
        check_eq("redir id_pc", id_pc,               32'h10);
        check_eq("redir cnt",   {16'b0, bubble_cnt}, 32'h1);
        redirect = 1'b0;
        stall    = 1'b0;
        tick();
        check_eq("post-redir id_pc", id_pc,             32'h100);
        check_eq("post-redir valid", {31'b0, id_valid}, 32'h1);
        check_eq("post-redir addr",  imem_addr,         32'h104);

        // Two memory wait cycles at pc=0x20.
        redirect    = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect   = 1'b0;
        imem_valid = 1'b0;
        tick();
        check_eq("wait1 addr",  imem_addr,           32'h20);
        check_eq("wait1 valid", {31'b0, id_valid},   32'h0);
        check_eq("wait1 cnt",   {16'b0, bubble_cnt}, 32'h3);
        tick();
        check_eq("wait2 addr",  imem_addr,           32'h20);
        check_eq("wait2 cnt",   {16'b0, bubble_cnt}, 32'h4);
        imem_valid = 1'b1;
        imem_rdata = 32'h00A0_0113;
        tick();
        check_eq("wait-end id_pc",  id_pc,              32'h20);
        check_eq("wait-end instr",  id_instr,           32'h00A0_0113);
        check_eq("wait-end opcode", {25'b0, id_opcode}, 32'h13);
        check_eq("wait-end addr",   imem_addr,          32'h24);

        // PC wrap from the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        check_eq("wrap pre addr", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0;
        tick();
        check_eq("wrap addr",  imem_addr,           32'h0);
        check_eq("wrap id_pc", id_pc,               32'hFFFF_FFFC);
        check_eq("wrap cnt",   {16'b0, bubble_cnt}, 32'h5);

        // Drive the bubble counter to saturation with wait cycles.
        imem_valid = 1'b0;
        repeat (65529) tick();
        check_eq("cnt pre-sat", {16'b0, bubble_cnt}, 32'hFFFE);
        tick();
        check_eq("cnt sat",     {16'b0, bubble_cnt}, 32'hFFFF);
        tick();
        check_eq("cnt hold",    {16'b0, bubble_cnt}, 32'hFFFF);
        imem_valid = 1'b1;
        tick();
        check_eq("sat fetch id_pc", id_pc, 32'h0);

        // Asynchronous reset asserted mid-cycle during a stall.
        stall = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async");
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        tick();
        check_eq("restart id_pc", id_pc,             32'h0);
        check_eq("restart valid", {31'b0, id_valid}, 32'h1);
        check_eq("restart addr",  imem_addr,         32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
